// File: rtl/guess_game_ctrl_pkg.sv
// Shared definitions for the number-guessing game controller: FSM states, hint codes
// and the small arithmetic helpers used by the top level.
package guess_game_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StGuess = 3'd1,
    StCheck = 3'd2,
    StWin   = 3'd3,
    StLose  = 3'd4
  } state_e;

  localparam logic [1:0] HINT_NONE = 2'b00;
  localparam logic [1:0] HINT_LOW  = 2'b01;
  localparam logic [1:0] HINT_HIGH = 2'b10;
  localparam logic [1:0] HINT_OK   = 2'b11;

  // Two-digit BCD increment; 99 saturates.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (units != 4'd9) begin
      units = units + 4'd1;
    end else if (tens != 4'd9) begin
      units = 4'd0;
      tens  = tens + 4'd1;
    end
    return {tens, units};
  endfunction

  // Fibonacci form of x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [3:0] secret_digit(input logic [3:0] n);
    return (n >= 4'd10) ? (n - 4'd10) : n;
  endfunction

  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : (d + 4'd1);
  endfunction

  function automatic logic [3:0] digit_dec(input logic [3:0] d);
    return (d == 4'd0) ? 4'd9 : (d - 4'd1);
  endfunction

endpackage

// File: rtl/guess_game_ctrl_key_debounce.sv
// Push-button conditioner: two-flop synchroniser plus a stability counter. Emits one
// 1-cycle pulse per debounced press (high->low); releases are debounced silently.
module guess_game_ctrl_key_debounce #(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd1_000_000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic key_n,
  output logic press_pulse
);

  logic [1:0]  sync_q;
  logic        level_q;
  logic [19:0] cnt_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_q      <= 2'b11;
      level_q     <= 1'b1;
      cnt_q       <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], key_n};
      press_pulse <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEBOUNCE_CYC - 20'd1) begin
        // New level has held long enough; only the falling edge is a press.
        cnt_q       <= '0;
        level_q     <= sync_q[1];
        press_pulse <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 20'd1;
      end
    end
  end

endmodule

// File: rtl/guess_game_ctrl.sv
// Number-guessing game controller: debounced keys, free-running LFSR secret source,
// game FSM and registered display outputs (guess/secret digit, BCD tries, hint).
module guess_game_ctrl
  import guess_game_ctrl_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd1_000_000,
  parameter logic [7:0]  MAX_TRIES    = 8'h09,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       KEY_Inc,
  input  logic       KEY_Dec,
  input  logic       KEY_Enter,
  output logic [3:0] data,
  output logic [7:0] tries,
  output logic [1:0] hint,
  output logic       game_over
);

  logic inc_p;
  logic dec_p;
  logic enter_p;

  guess_game_ctrl_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .key_n       (KEY_Inc),
    .press_pulse (inc_p)
  );

  guess_game_ctrl_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dec (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .key_n       (KEY_Dec),
    .press_pulse (dec_p)
  );

  guess_game_ctrl_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_enter (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .key_n       (KEY_Enter),
    .press_pulse (enter_p)
  );

  logic [7:0] lfsr_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  state_e     state_q;
  logic [3:0] guess_q;
  logic [3:0] secret_q;
  logic [7:0] tries_nx;
  logic [1:0] hint_cmp;
  logic [3:0] guess_inc;
  logic [3:0] guess_dec;

  always_comb begin
    tries_nx  = bcd_inc(tries);
    guess_inc = digit_inc(guess_q);
    guess_dec = digit_dec(guess_q);
    hint_cmp  = HINT_OK;
    if (guess_q < secret_q) begin
      hint_cmp = HINT_LOW;
    end else if (guess_q > secret_q) begin
      hint_cmp = HINT_HIGH;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= StIdle;
      guess_q   <= 4'd0;
      secret_q  <= 4'd0;
      data      <= 4'd0;
      tries     <= 8'h00;
      hint      <= HINT_NONE;
      game_over <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enter_p) begin
            secret_q <= secret_digit(lfsr_q[3:0]);
            guess_q  <= 4'd0;
            data     <= 4'd0;
            tries    <= 8'h00;
            hint     <= HINT_NONE;
            state_q  <= StGuess;
          end
        end
        StGuess: begin
          if (enter_p) begin
            state_q <= StCheck;
          end else if (inc_p) begin
            guess_q <= guess_inc;
            data    <= guess_inc;
          end else if (dec_p) begin
            guess_q <= guess_dec;
            data    <= guess_dec;
          end
        end
        StCheck: begin
          tries <= tries_nx;
          hint  <= hint_cmp;
          if (guess_q == secret_q) begin
            state_q   <= StWin;
            data      <= secret_q;
            game_over <= 1'b1;
          end else if (tries_nx == MAX_TRIES) begin
            state_q   <= StLose;
            data      <= secret_q;
            game_over <= 1'b1;
          end else begin
            state_q <= StGuess;
          end
        end
        StWin, StLose: begin
          // Restart clears the scoreboard so IDLE always shows a fresh display.
          if (enter_p) begin
            state_q   <= StIdle;
            guess_q   <= 4'd0;
            data      <= 4'd0;
            tries     <= 8'h00;
            hint      <= HINT_NONE;
            game_over <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
